// File: rtl/rv_imem_bridge.sv
// Fetch-side to pipelined Wishbone instruction bridge: one request in flight,
// stale responses discarded, bus errors and timeouts reported as faults.
module rv_imem_bridge #(
    parameter int IADDR_SPACE_BITS = 16,
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int TIMEOUT_BITS     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [IADDR_SPACE_BITS-1:0] i_addr,
    input  logic                        i_cyc,
    output logic                        o_ack,
    output logic [31:0]                 o_instruction,
    output logic [IADDR_SPACE_BITS-1:0] o_wb_adr,
    output logic                        o_wb_cyc,
    output logic                        o_wb_stb,
    input  logic                        i_wb_stall,
    input  logic                        i_wb_ack,
    input  logic                        i_wb_err,
    input  logic [31:0]                 i_wb_dat,
    output logic                        o_fault,
    output logic [IADDR_SPACE_BITS-1:0] o_fault_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [IADDR_SPACE_BITS-1:0] WORD_MASK = ~IADDR_SPACE_BITS'(3);

    state_t                        state;
    state_t                        state_next;
    logic [IADDR_SPACE_BITS-1:0]   req_adr;
    logic [IADDR_SPACE_BITS-1:0]   fetch_adr;
    logic [TIMEOUT_BITS-1:0]       timer;
    logic                          hit;
    logic                          timed_out;

    assign fetch_adr = i_addr & WORD_MASK;
    assign hit       = i_cyc && (fetch_adr == req_adr);
    // Timer holds cycles already spent in DATA, so the fault lands in the
    // TIMEOUT_CYCLES-th DATA cycle.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (int'(timer) == TIMEOUT_CYCLES - 1);

    assign o_wb_cyc = (state != IDLE);
    assign o_wb_stb = (state == ADDR);
    assign o_wb_adr = req_adr;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        o_ack      = 1'b0;
        o_fault    = 1'b0;
        case (state)
            IDLE: if (i_cyc) state_next = ADDR;
            ADDR: if (!i_wb_stall) state_next = DATA;
            DATA: begin
                if (i_wb_err) begin
                    o_fault    = 1'b1;
                    state_next = IDLE;
                end else if (i_wb_ack) begin
                    o_ack      = hit;
                    state_next = IDLE;
                end else if (timed_out) begin
                    o_fault    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            req_adr       <= '0;
            timer         <= '0;
            o_instruction <= '0;
            o_fault_addr  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_cyc) req_adr <= fetch_adr;
            if (state == ADDR) begin
                timer <= '0;
            end else if (state == DATA && timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (o_ack) o_instruction <= i_wb_dat;
            if (o_fault) o_fault_addr <= req_adr;
        end
    end

endmodule

// File: tb/tb_rv_imem_bridge.sv
// Bench for rv_imem_bridge: directed scenarios with literal expectations, then
// randomized fetch/slave traffic checked every cycle against a transaction model.
module tb_rv_imem_bridge;

    localparam int AW = 16;
    localparam int TO = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic [AW-1:0] i_addr;
    logic          i_cyc;
    logic          o_ack;
    logic [31:0]   o_instruction;
    logic [AW-1:0] o_wb_adr;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [31:0]   i_wb_dat;
    logic          o_fault;
    logic [AW-1:0] o_fault_addr;

    int checks = 0;
    int errors = 0;

    rv_imem_bridge #(
        .IADDR_SPACE_BITS(AW),
        .TIMEOUT_CYCLES  (TO),
        .TIMEOUT_BITS    (8)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_addr       (i_addr),
        .i_cyc        (i_cyc),
        .o_ack        (o_ack),
        .o_instruction(o_instruction),
        .o_wb_adr     (o_wb_adr),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .i_wb_stall   (i_wb_stall),
        .i_wb_ack     (i_wb_ack),
        .i_wb_err     (i_wb_err),
        .i_wb_dat     (i_wb_dat),
        .o_fault      (o_fault),
        .o_fault_addr (o_fault_addr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request is either absent, waiting for its
    // address to be taken, or waiting for a response for some number of cycles.
    logic          m_busy = 1'b0;
    logic          m_taken = 1'b0;
    logic [AW-1:0] m_req = '0;
    int            m_wait = 0;
    logic [31:0]   m_instr = '0;
    logic [AW-1:0] m_faddr = '0;
    logic          e_ack, e_fault, e_hit, e_to;

    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            m_busy = 1'b0; m_taken = 1'b0; m_req = '0; m_wait = 0;
            m_instr = '0; m_faddr = '0;
            check("rst_cyc", 32'(o_wb_cyc), 32'd0);
            check("rst_stb", 32'(o_wb_stb), 32'd0);
            check("rst_ack", 32'(o_ack), 32'd0);
            check("rst_fault", 32'(o_fault), 32'd0);
            check("rst_adr", 32'(o_wb_adr), 32'd0);
            check("rst_instr", o_instruction, 32'd0);
            check("rst_faddr", 32'(o_fault_addr), 32'd0);
        end else begin
            e_ack = 1'b0; e_fault = 1'b0; e_to = 1'b0; e_hit = 1'b0;
            if (m_busy && m_taken) begin
                e_hit   = i_cyc && ((i_addr >> 2) == (m_req >> 2));
                e_to    = !i_wb_ack && !i_wb_err && (m_wait + 1 == TO);
                e_ack   = i_wb_ack && !i_wb_err && e_hit;
                e_fault = i_wb_err || e_to;
            end
            check("cyc", 32'(o_wb_cyc), 32'(m_busy));
            check("stb", 32'(o_wb_stb), 32'(m_busy && !m_taken));
            if (m_busy && !m_taken) check("adr", 32'(o_wb_adr), 32'(m_req));
            check("ack", 32'(o_ack), 32'(e_ack));
            check("fault", 32'(o_fault), 32'(e_fault));
            check("instr", o_instruction, m_instr);
            check("faddr", 32'(o_fault_addr), 32'(m_faddr));
            if (!m_busy) begin
                if (i_cyc) begin
                    m_busy = 1'b1; m_taken = 1'b0; m_req = i_addr & 16'hFFFC;
                end
            end else if (!m_taken) begin
                if (!i_wb_stall) begin
                    m_taken = 1'b1; m_wait = 0;
                end
            end else if (i_wb_ack || i_wb_err || e_to) begin
                m_busy = 1'b0;
                if (e_ack) m_instr = i_wb_dat;
                if (e_fault) m_faddr = m_req;
            end else begin
                m_wait++;
            end
        end
    end

    // Drives one cycle's inputs just after the clock edge and returns mid-cycle.
    task automatic step(input logic cyc, input logic [AW-1:0] addr, input logic stall,
                        input logic ack, input logic err, input logic [31:0] dat);
        @(posedge i_clk);
        #1;
        i_cyc = cyc; i_addr = addr; i_wb_stall = stall;
        i_wb_ack = ack; i_wb_err = err; i_wb_dat = dat;
        #3;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] base;
        case ($urandom_range(0, 3))
            0: base = 16'h0010;
            1: base = 16'h0014;
            2: base = 16'h0200;
            default: base = 16'hFFFC;
        endcase
        return base | AW'($urandom_range(0, 3));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_cyc;
        int n_fault;
        logic [AW-1:0] cur_addr;
        i_reset_n = 1'b0; i_cyc = 1'b0; i_addr = '0; i_wb_stall = 1'b0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;

        // Zero-wait read
        step(1, 16'h0104, 0, 0, 0, 0);
        check("zw_idle_cyc", 32'(o_wb_cyc), 32'd0);
        step(1, 16'h0104, 0, 0, 0, 0);
        check("zw_stb", 32'(o_wb_stb), 32'd1);
        check("zw_adr", 32'(o_wb_adr), 32'h0104);
        step(1, 16'h0104, 0, 1, 0, 32'hDEADBEEF);
        check("zw_ack_latency2", 32'(o_ack), 32'd1);
        step(0, 16'h0104, 0, 0, 0, 0);
        check("zw_instr", o_instruction, 32'hDEADBEEF);
        check("zw_back_idle", 32'(o_wb_cyc), 32'd0);

        // Stall for 3 cycles, ack in 4th DATA cycle
        step(1, 16'h0108, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 16'h0108, (k < 3), 0, 0, 0);
            check("st_stb", 32'(o_wb_stb), 32'd1);
            check("st_adr", 32'(o_wb_adr), 32'h0108);
        end
        n_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 16'h0108, 0, (k == 3), 0, 32'h12345678);
            if (o_ack) n_cyc++;
        end
        check("st_single_ack", 32'(n_cyc), 32'd1);

        // Redirect during DATA: stale response dropped, new address issued
        step(1, 16'h0010, 0, 0, 0, 0);
        step(1, 16'h0010, 0, 0, 0, 0);
        step(1, 16'h0200, 0, 0, 0, 0);
        step(1, 16'h0200, 0, 1, 0, 32'hAAAA0000);
        check("rd_drop_ack", 32'(o_ack), 32'd0);
        step(1, 16'h0200, 0, 0, 0, 0);
        check("rd_instr_kept", o_instruction, 32'h12345678);
        step(1, 16'h0200, 0, 0, 0, 0);
        check("rd_new_adr", 32'(o_wb_adr), 32'h0200);
        step(1, 16'h0200, 0, 1, 0, 32'hBBBB0000);
        check("rd_new_ack", 32'(o_ack), 32'd1);
        step(0, 16'h0200, 0, 0, 0, 0);
        check("rd_new_instr", o_instruction, 32'hBBBB0000);

        // Error together with ack
        step(1, 16'h0020, 0, 0, 0, 0);
        step(1, 16'h0020, 0, 0, 0, 0);
        step(1, 16'h0020, 0, 1, 1, 32'hCCCC0000);
        check("er_fault", 32'(o_fault), 32'd1);
        check("er_no_ack", 32'(o_ack), 32'd0);
        step(0, 16'h0020, 0, 0, 0, 0);
        check("er_faddr", 32'(o_fault_addr), 32'h0020);
        check("er_pulse", 32'(o_fault), 32'd0);
        check("er_instr_kept", o_instruction, 32'hBBBB0000);

        // Timeout with a silent slave; cyc low during ADDR keeps the strobe
        step(1, 16'h0030, 0, 0, 0, 0);
        step(0, 16'h0030, 0, 0, 0, 0);
        check("to_stb_held", 32'(o_wb_stb), 32'd1);
        n_cyc = 0; n_fault = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 16'h0030, 0, 0, 0, 0);
            if (o_wb_cyc) n_cyc++;
            if (o_fault) n_fault++;
        end
        check("to_data_cycles", 32'(n_cyc), 32'd4);
        check("to_fault_count", 32'(n_fault), 32'd1);
        check("to_faddr", 32'(o_fault_addr), 32'h0030);
        step(0, 16'h0030, 0, 1, 0, 32'h55555555);
        check("to_stray_ack", 32'(o_ack), 32'd0);
        step(0, 16'h0030, 0, 0, 0, 0);
        check("to_stray_instr", o_instruction, 32'hBBBB0000);

        // Async reset during DATA
        step(1, 16'h0040, 0, 0, 0, 0);
        step(1, 16'h0040, 0, 0, 0, 0);
        step(1, 16'h0040, 0, 0, 0, 0);
        i_reset_n = 1'b0; i_cyc = 1'b0; i_wb_ack = 1'b1; i_wb_dat = 32'h77777777;
        #2;
        check("ar_cyc", 32'(o_wb_cyc), 32'd0);
        check("ar_ack", 32'(o_ack), 32'd0);
        check("ar_instr", o_instruction, 32'd0);
        check("ar_faddr", 32'(o_fault_addr), 32'd0);
        i_wb_ack = 1'b0;
        #1 i_reset_n = 1'b1;
        step(1, 16'h0046, 0, 0, 0, 0);
        step(1, 16'h0046, 0, 0, 0, 0);
        check("ar_new_adr", 32'(o_wb_adr), 32'h0044);
        step(1, 16'h0046, 0, 1, 0, 32'hC0DE0001);
        check("ar_new_ack", 32'(o_ack), 32'd1);
        step(0, 16'h0046, 0, 0, 0, 0);
        check("ar_new_instr", o_instruction, 32'hC0DE0001);

        // Randomized traffic; only the model judges these cycles
        cur_addr = pick_addr();
        for (int n = 0; n < 3000; n++) begin
            @(posedge i_clk);
            #1;
            if ($urandom_range(0, 4) == 0) cur_addr = pick_addr();
            i_addr     = cur_addr;
            i_cyc      = ($urandom_range(0, 6) != 0);
            i_wb_stall = ($urandom_range(0, 2) == 0);
            i_wb_dat   = $urandom;
            if (o_wb_cyc && !o_wb_stb) begin
                i_wb_ack = ($urandom_range(0, 9) < 3);
                i_wb_err = ($urandom_range(0, 9) == 0);
            end else if (!o_wb_cyc) begin
                i_wb_ack = ($urandom_range(0, 19) == 0);
                i_wb_err = ($urandom_range(0, 39) == 0);
            end else begin
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
            end
            #3;
        end

        @(posedge i_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_imem_bridge.md
Name: rv_imem_bridge

Overview:
Instruction-bus bridge between the fetch stage's request interface (addr/cyc in; ack/instruction out) and a pipelined Wishbone-style instruction memory bus. It keeps at most one request outstanding, converts variable-latency bus responses into the fetch stage's timing (ack pulse, data one cycle later), and silently discards responses made stale by redirects or fetch-side back-pressure. Bus errors and timeouts are reported as faults to the trap logic.

Parameters:
IADDR_SPACE_BITS, 16, width of instruction address space (bytes)
TIMEOUT_CYCLES, 255, cycles in DATA state before timeout fault; 0 disables timeout
TIMEOUT_BITS, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_addr  in  IADDR_SPACE_BITS  fetch byte address; bits [1:0] ignored
i_cyc  in  1  fetch wants a word at i_addr
o_ack  out  1  one-cycle pulse: word for current i_addr accepted
o_instruction  out  32  fetched word, valid the cycle after o_ack, held until next o_ack
o_wb_adr  out  IADDR_SPACE_BITS  bus word address, bits [1:0] forced 0
o_wb_cyc  out  1  bus cycle active
o_wb_stb  out  1  address-phase strobe
i_wb_stall  in  1  slave cannot accept address this cycle
i_wb_ack  in  1  read data valid on i_wb_dat
i_wb_err  in  1  bus error terminates cycle
i_wb_dat  in  32  read data
o_fault  out  1  one-cycle pulse on bus error or timeout
o_fault_addr  out  IADDR_SPACE_BITS  word address of faulting request, held until next fault

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_ack=0, o_wb_cyc=0, o_wb_stb=0, o_fault=0, o_wb_adr=0, o_fault_addr=0, o_instruction=0, timeout counter=0, request latch=0. Reset mid-transaction abandons it; any later i_wb_ack/i_wb_err is ignored in IDLE.
- Request latch req_adr = {i_addr[IADDR_SPACE_BITS-1:2],2'b00} captured on IDLE->ADDR.
- States:
  - IDLE: o_wb_cyc=0. If i_cyc: latch req_adr, -> ADDR next cycle.
  - ADDR: o_wb_cyc=1, o_wb_stb=1, o_wb_adr=req_adr. If !i_wb_stall -> DATA (stb drops next cycle); else stay.
  - DATA: o_wb_cyc=1, o_wb_stb=0; timeout counter increments each cycle. On i_wb_ack -> IDLE; on i_wb_err -> IDLE with fault; on counter reaching TIMEOUT_CYCLES (if nonzero) -> IDLE with fault.
- Ack/data delivery in DATA on i_wb_ack: hit = i_cyc & (i_addr[MSB:2]==req_adr[MSB:2]). If hit: o_ack=1 combinationally that cycle; o_instruction <= i_wb_dat (registered, visible next cycle). If !hit: response discarded, no o_ack, o_instruction unchanged.
- o_ack asserted only in DATA with i_wb_ack and hit; never in ADDR or IDLE. Minimum request-to-ack latency 2 cycles (IDLE, ADDR, DATA-with-ack).
- Redirect mid-request: address change observed through i_addr only; request always completes on the bus (no abort), stale data discarded; next IDLE latches new address. i_cyc low during ADDR does not withdraw the strobe.
- i_wb_ack and i_wb_err same cycle: err wins; no o_ack, fault raised.
- Fault: o_fault=1 for one cycle in the terminating cycle; o_fault_addr <= req_adr. Fault raised regardless of hit.
- Timeout counter cleared on entering DATA; saturating, width TIMEOUT_BITS.
- Back-to-back: IDLE is always spent for one cycle between requests (no pipelining).

Test Plan:
- Zero-wait read: i_cyc=1, i_addr=0x0104, no stall, slave acks first DATA cycle with 0xDEADBEEF -> o_wb_adr=0x0104 in ADDR, o_ack pulse 2 cycles after request, o_instruction=0xDEADBEEF next cycle.
- Stall + wait states: i_wb_stall=1 for 3 cycles, ack 4 cycles into DATA -> stb held 4 cycles, single o_ack, o_wb_adr stable throughout.
- Redirect: i_addr changes 0x0010->0x0200 during DATA -> response for 0x0010 dropped (no o_ack), next request issues o_wb_adr=0x0200, acked normally.
- Bus error: i_wb_err with i_wb_ack in same cycle for 0x0020 -> o_fault pulse, o_fault_addr=0x0020, no o_ack, o_instruction unchanged.
- Timeout: TIMEOUT_CYCLES=4, slave never responds -> o_wb_cyc drops after 4 DATA cycles, o_fault pulse; later stray i_wb_ack ignored.
- Async reset during DATA -> all outputs 0 immediately; after release, fresh request at i_addr issued correctly.
